mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single synchronous 16-bit memory port between the processor and a second bus master (DMA/loader).
- Each master uses a req/gnt handshake. The arbiter registers the winning access onto the memory port and tracks in-flight reads.
- It routes each read return back to its originator with a one-cycle rvalid pulse.
- It sits between the masters and the memory/IO address decoder.

Parameters:
AW, 16, address width
DW, 16, data width
RD_LAT, 1, memory read latency in clock edges from mem_addr presented to mem_rdata valid; legal range 1..4

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
req0  in  1  master 0 access request; held until gnt0 seen
we0  in  1  master 0 write enable, stable while req0 high
addr0  in  AW  master 0 address
wdata0  in  DW  master 0 write data
gnt0  out  1  one-cycle pulse: master 0 access issued to memory this cycle
rvalid0  out  1  one-cycle pulse: rdata0 holds master 0 read result
rdata0  out  DW  master 0 read data, held until next master 0 return
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as master 0, for master 1
mem_addr  out  AW  registered memory address
mem_wdata  out  DW  registered memory write data
mem_we  out  1  registered memory write strobe
mem_rdata  in  DW  synchronous memory read data
busy  out  1  high while any read is in flight or a gnt is asserted

Behaviour:
- Reset (async, any time):
  - gnt0/1, rvalid0/1, mem_we and busy go to 0.
  - rdata0/1, mem_addr and mem_wdata go to 0.
  - The tag pipeline is cleared and last = 1, so master 0 wins first.
  - In-flight reads are dropped; no rvalid may appear for them after reset is released.
- Eligibility: req_k counts only in cycles where gnt_k is low. A request sampled while gnt_k is high is ignored, which prevents double issue. A single master therefore gets at most one access every 2 cycles.
- Arbitration, evaluated on every rising edge:
  - Neither master eligible: gnt0 = gnt1 = 0 and mem_we = 0; mem_addr and mem_wdata hold their values.
  - Exactly one master eligible: that master wins.
  - Both eligible: the master != last wins (round-robin). last updates to the winner on every grant.
- Issue, at edge E:
  - mem_addr <= addr_w, mem_wdata <= wdata_w, mem_we <= we_w.
  - gnt_w <= 1 for exactly one cycle; the other gnt <= 0.
  - mem_we is never high for more than one cycle per grant.
- Read tracking:
  - Every issued read pushes {valid = 1, id = w} into an RD_LAT-deep tag shift register; writes and idle cycles push valid = 0.
  - When the tag exits, at edge E + RD_LAT + 1: rdata_id <= mem_rdata and rvalid_id <= 1 for one cycle.
  - rvalid is therefore high in the cycle RD_LAT + 1 cycles after gnt was high.
  - The other master's rdata is unchanged.
- Writes produce no rvalid.
- Ordering: accesses complete in issue order. A read issued after a write to the same address returns the written data.
- Simultaneity: a read return and a new issue in the same edge are independent; both happen. Back-to-back reads give back-to-back rvalids, alternating by id when the masters alternate.
- Throughput: with both masters requesting continuously, one access per cycle, grants alternating 0,1,0,1.
- busy = OR of tag valid bits OR gnt0 OR gnt1, registered consistently with the outputs.

Test Plan:
- Reset held, then released with both req low → all outputs 0; first edge with req0 = req1 = 1 gives gnt0 = 1, mem_addr = addr0.
- Master 0 read addr 0x0010, memory model returns 0xBEEF with RD_LAT = 1 → gnt0 at cycle N, mem_we = 0, rvalid0 = 1 at N+2 with rdata0 = 0xBEEF; rvalid1 stays 0.
- Both masters request continuously, reads from 0x0001 (M0) and 0x0002 (M1), for 8 cycles → gnt order 0,1,0,1…; mem_addr alternates 0x0001/0x0002; each rvalid is routed to the correct master with the matching data.
- Master 1 writes 0x1234 to 0x0040, then master 0 reads 0x0040 → exactly one mem_we = 1 cycle with mem_wdata = 0x1234; rdata0 = 0x1234; no rvalid1.
- Master 0 holds req0 high for 6 cycles, master 1 idle → gnt0 pulses every 2nd cycle (3 grants); no double issue.
- Reset asserted mid-read, one cycle after gnt1 with RD_LAT = 2 → rvalid1 never asserts; busy = 0 immediately; after release the next grant is to master 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Per-master request/grant and read-return bundle for mem_arbiter.
// The master drives the request side; the arbiter drives grants and read returns.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for one synchronous memory port.
// Read returns are routed back to their originator through a tag pipeline.
module mem_arbiter #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          Clock,
   input  logic          Reset,
   mem_arbiter_if.slave  m0,
   mem_arbiter_if.slave  m1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   logic              gnt0_q;
   logic              gnt1_q;
   logic              last_q;
   logic              mem_we_q;
   logic [AW-1:0]     mem_addr_q;
   logic [DW-1:0]     mem_wdata_q;
   logic              rv0_q;
   logic              rv1_q;
   logic [DW-1:0]     rd0_q;
   logic [DW-1:0]     rd1_q;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_id;

   logic              elig0;
   logic              elig1;
   logic              win0;
   logic              win1;
   logic              win_any;
   logic              sel_we;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic              rd_new;
   logic              rd_id;
   logic              tag_out_v;
   logic              tag_out_id;

   always_comb begin
      elig0     = m0.req & ~gnt0_q;
      elig1     = m1.req & ~gnt1_q;
      win0      = elig0 & (~elig1 | last_q);
      win1      = elig1 & ~win0;
      win_any   = win0 | win1;
      sel_we    = win1 ? m1.we    : m0.we;
      sel_addr  = win1 ? m1.addr  : m0.addr;
      sel_wdata = win1 ? m1.wdata : m0.wdata;
   end

   // The grant register is the first stage of the read pipeline.
   assign rd_new     = (gnt0_q | gnt1_q) & ~mem_we_q;
   assign rd_id      = gnt1_q;
   assign tag_out_v  = tag_v[RD_LAT-1];
   assign tag_out_id = tag_id[RD_LAT-1];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         last_q      <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rv0_q       <= 1'b0;
         rv1_q       <= 1'b0;
         rd0_q       <= '0;
         rd1_q       <= '0;
         tag_v       <= '0;
         tag_id      <= '0;
      end else begin
         gnt0_q   <= win0;
         gnt1_q   <= win1;
         mem_we_q <= win_any & sel_we;
         if (win_any) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            last_q      <= win1;
         end
         tag_v[0]  <= rd_new;
         tag_id[0] <= rd_id;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         rv0_q <= tag_out_v & ~tag_out_id;
         rv1_q <= tag_out_v & tag_out_id;
         if (tag_out_v & ~tag_out_id)
            rd0_q <= mem_rdata;
         if (tag_out_v & tag_out_id)
            rd1_q <= mem_rdata;
      end
   end

   assign m0.gnt    = gnt0_q;
   assign m1.gnt    = gnt1_q;
   assign m0.rvalid = rv0_q;
   assign m1.rvalid = rv1_q;
   assign m0.rdata  = rd0_q;
   assign m1.rdata  = rd1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign busy      = (|tag_v) | gnt0_q | gnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with behavioural memories
// at read latency 1 (main instance) and 2 (reset/latency instance).
module tb_mem_arbiter;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   mem_arbiter_if #(.AW(16), .DW(16)) a0 ();
   mem_arbiter_if #(.AW(16), .DW(16)) a1 ();
   mem_arbiter_if #(.AW(16), .DW(16)) b0 ();
   mem_arbiter_if #(.AW(16), .DW(16)) b1 ();

   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, busy;
   logic [15:0] mem_addr2, mem_wdata2, mem_rdata2;
   logic        mem_we2, busy2;

   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .m0        (a0),
      .m1        (a1),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   mem_arbiter #(.AW(16), .DW(16), .RD_LAT(2)) dut2 (
      .Clock     (Clock),
      .Reset     (Reset),
      .m0        (b0),
      .m1        (b1),
      .mem_addr  (mem_addr2),
      .mem_wdata (mem_wdata2),
      .mem_we    (mem_we2),
      .mem_rdata (mem_rdata2),
      .busy      (busy2)
   );

   // Memory models: word at a = {A5, a[7:0]}, except 0x10 = BEEF
   logic [15:0] mem1 [256];
   logic [15:0] mem2 [256];
   logic [15:0] p2a, p2b;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = {8'hA5, 8'(i)};
         mem2[i] = {8'hA5, 8'(i)};
      end
      mem1[8'h10] = 16'hBEEF;
      mem2[8'h10] = 16'hBEEF;
   end

   always @(posedge Clock) begin
      if (mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem1[mem_addr[7:0]];
   end

   always @(posedge Clock) begin
      if (mem_we2) mem2[mem_addr2[7:0]] <= mem_wdata2;
      p2a <= mem2[mem_addr2[7:0]];
      p2b <= p2a;
   end
   assign mem_rdata2 = p2b;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h",
                  nm, idx, act, exp);
      end
   endtask

   typedef struct {
      logic        r0, w0;
      logic [15:0] a0, d0;
      logic        r1, w1;
      logic [15:0] a1, d1;
      logic        g0, g1, we;
      logic [15:0] ma, md;
      logic        v0, v1;
      logic [15:0] q0, q1;
      logic        bz;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
      logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
      logic g0, logic g1, logic we,
      logic [15:0] ma, logic [15:0] md,
      logic v0, logic v1,
      logic [15:0] q0, logic [15:0] q1, logic bz);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.we = we;
      v.ma = ma; v.md = md;
      v.v0 = v0; v.v1 = v1;
      v.q0 = q0; v.q1 = q1; v.bz = bz;
      return v;
   endfunction

   task automatic idle_inputs();
      a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0;
      a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
      b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;
      b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0;
   endtask

   logic seen_rv;

   initial begin
      idle_inputs();

      // Reset-to-first-grant, then single reads from each master
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0000,0, 0,0,16'h0000,16'h0000,0));
      vq.push_back(mk(1,0,16'h0010,0, 1,0,16'h0020,0,
                      1,0,0,16'h0010,0, 0,0,16'h0000,16'h0000,1));
      vq.push_back(mk(0,0,16'h0000,0, 1,0,16'h0020,0,
                      0,1,0,16'h0020,0, 0,0,16'h0000,16'h0000,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0020,0, 1,0,16'hBEEF,16'h0000,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0020,0, 0,1,16'hBEEF,16'hA520,0));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0020,0, 0,0,16'hBEEF,16'hA520,0));
      // Both masters streaming reads
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      1,0,0,16'h0001,0, 0,0,16'hBEEF,16'hA520,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      0,1,0,16'h0002,0, 0,0,16'hBEEF,16'hA520,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      1,0,0,16'h0001,0, 1,0,16'hA501,16'hA520,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      0,1,0,16'h0002,0, 0,1,16'hA501,16'hA502,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      1,0,0,16'h0001,0, 1,0,16'hA501,16'hA502,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      0,1,0,16'h0002,0, 0,1,16'hA501,16'hA502,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      1,0,0,16'h0001,0, 1,0,16'hA501,16'hA502,1));
      vq.push_back(mk(1,0,16'h0001,0, 1,0,16'h0002,0,
                      0,1,0,16'h0002,0, 0,1,16'hA501,16'hA502,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0002,0, 1,0,16'hA501,16'hA502,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0002,0, 0,1,16'hA501,16'hA502,0));
      // M1 write then M0 read of the same address
      vq.push_back(mk(0,0,16'h0000,0, 1,1,16'h0040,16'h1234,
                      0,1,1,16'h0040,16'h1234, 0,0,16'hA501,16'hA502,1));
      vq.push_back(mk(1,0,16'h0040,0, 0,0,16'h0000,0,
                      1,0,0,16'h0040,0, 0,0,16'hA501,16'hA502,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0040,0, 0,0,16'hA501,16'hA502,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0040,0, 1,0,16'h1234,16'hA502,0));
      // M0 holds req for 6 cycles: grant every other cycle
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      1,0,0,16'h0005,0, 0,0,16'h1234,16'hA502,1));
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      0,0,0,16'h0005,0, 0,0,16'h1234,16'hA502,1));
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      1,0,0,16'h0005,0, 1,0,16'hA505,16'hA502,1));
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      0,0,0,16'h0005,0, 0,0,16'hA505,16'hA502,1));
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      1,0,0,16'h0005,0, 1,0,16'hA505,16'hA502,1));
      vq.push_back(mk(1,0,16'h0005,0, 0,0,16'h0000,0,
                      0,0,0,16'h0005,0, 0,0,16'hA505,16'hA502,1));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0005,0, 1,0,16'hA505,16'hA502,0));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0,
                      0,0,0,16'h0005,0, 0,0,16'hA505,16'hA502,0));

      // Outputs while reset is held
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_busy", -1, 16'(busy), 16'h0);
      chk("rst_gnt", -1, {14'h0, a1.gnt, a0.gnt}, 16'h0);
      chk("rst_addr", -1, mem_addr, 16'h0);
      Reset = 1'b0;

      foreach (vq[i]) begin
         a0.req = vq[i].r0; a0.we = vq[i].w0;
         a0.addr = vq[i].a0; a0.wdata = vq[i].d0;
         a1.req = vq[i].r1; a1.we = vq[i].w1;
         a1.addr = vq[i].a1; a1.wdata = vq[i].d1;
         @(posedge Clock);
         #1;
         chk("gnt0", i, 16'(a0.gnt), 16'(vq[i].g0));
         chk("gnt1", i, 16'(a1.gnt), 16'(vq[i].g1));
         chk("mem_we", i, 16'(mem_we), 16'(vq[i].we));
         chk("mem_addr", i, mem_addr, vq[i].ma);
         chk("mem_wdata", i, mem_wdata, vq[i].md);
         chk("rvalid0", i, 16'(a0.rvalid), 16'(vq[i].v0));
         chk("rvalid1", i, 16'(a1.rvalid), 16'(vq[i].v1));
         chk("rdata0", i, a0.rdata, vq[i].q0);
         chk("rdata1", i, a1.rdata, vq[i].q1);
         chk("busy", i, 16'(busy), 16'(vq[i].bz));
      end
      idle_inputs();

      // Read latency 2: rvalid three cycles after the grant cycle
      b0.req = 1; b0.addr = 16'h0010;
      @(posedge Clock); #1;
      chk("l2_gnt0", 100, 16'(b0.gnt), 16'h1);
      b0.req = 0;
      @(posedge Clock); #1;
      chk("l2_rv0_early", 101, 16'(b0.rvalid), 16'h0);
      @(posedge Clock); #1;
      chk("l2_rv0_early", 102, 16'(b0.rvalid), 16'h0);
      chk("l2_busy", 102, 16'(busy2), 16'h1);
      @(posedge Clock); #1;
      chk("l2_rv0", 103, 16'(b0.rvalid), 16'h1);
      chk("l2_rdata0", 103, b0.rdata, 16'hBEEF);

      // Reset one cycle after gnt1 drops the in-flight read
      b1.req = 1; b1.addr = 16'h0030;
      @(posedge Clock); #1;
      chk("l2_gnt1", 110, 16'(b1.gnt), 16'h1);
      b1.req = 0;
      @(posedge Clock); #1;
      chk("l2_busy_fl", 111, 16'(busy2), 16'h1);
      Reset = 1'b1;
      #1;
      chk("rst_busy2", 112, 16'(busy2), 16'h0);
      chk("rst_busy1", 112, 16'(busy), 16'h0);
      chk("rst_rdata0", 112, a0.rdata, 16'h0);
      @(posedge Clock);
      @(posedge Clock); #1;
      Reset = 1'b0;
      seen_rv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge Clock); #1;
         if (b1.rvalid) seen_rv = 1'b1;
      end
      chk("no_rv1", 113, 16'(seen_rv), 16'h0);
      b0.req = 1; b0.addr = 16'h0007;
      b1.req = 1; b1.addr = 16'h0008;
      @(posedge Clock); #1;
      chk("post_gnt0", 114, 16'(b0.gnt), 16'h1);
      chk("post_gnt1", 114, 16'(b1.gnt), 16'h0);
      chk("post_addr", 114, mem_addr2, 16'h0007);
      idle_inputs();
      repeat (4) @(posedge Clock);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
